// File: rtl/hc_selftest_pkg.sv
// -----------------------------------------------------------------------------
// hc_selftest_pkg
// Shared definitions for the 74HC-series clocked self-test sequencers.
//   - state_t     : sequencer FSM states
//   - VEC_W       : stimulus vector width ({b[3:0], a[3:0]})
//   - GATE_CNT    : gates per package (quad parts)
//   - NO_FAIL     : first_fail_vec value meaning "no mismatch recorded yet"
//   - golden_xor  : reference behaviour of one 74HC86 package
//   - settle_len  : clamps a settle-cycle parameter into the counter's range
// -----------------------------------------------------------------------------
package hc_selftest_pkg;

  localparam int VEC_W    = 8;
  localparam int GATE_CNT = 4;
  localparam logic [VEC_W-1:0] NO_FAIL = 8'hFF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DRIVE,
    ST_SETTLE,
    ST_CHECK,
    ST_DONE
  } state_t;

  function automatic logic [GATE_CNT-1:0] golden_xor(
    input logic [GATE_CNT-1:0] a,
    input logic [GATE_CNT-1:0] b
  );
    return a ^ b;
  endfunction

  // A zero-cycle settle is meaningless for a registered stimulus path, and the
  // settle counter is 4 bits wide, so the effective length lives in 1..15.
  function automatic int settle_len(input int cyc);
    if (cyc < 1)  return 1;
    if (cyc > 15) return 15;
    return cyc;
  endfunction

endpackage

// File: rtl/hc86_ref_model.sv
// -----------------------------------------------------------------------------
// hc86_ref_model
// Combinational golden model of one 74HC86 quad 2-input XOR package.
//   a [3:0] : A inputs
//   b [3:0] : B inputs
//   y [3:0] : expected Y outputs (a ^ b)
// -----------------------------------------------------------------------------
module hc86_ref_model
  import hc_selftest_pkg::*;
(
  input  logic [GATE_CNT-1:0] a,
  input  logic [GATE_CNT-1:0] b,
  output logic [GATE_CNT-1:0] y
);

  assign y = golden_xor(a, b);

endmodule

// File: rtl/hc86_selftest_seq.sv
// -----------------------------------------------------------------------------
// hc86_selftest_seq
// Clocked stimulus sequencer and response checker for a 74HC86 model.
// Walks all 256 {b,a} input combinations in ascending order, lets each one
// settle for SETTLE_CYC cycles, samples resp_y and compares it against the
// golden XOR. Each vector costs 2 + SETTLE_CYC cycles (DRIVE, SETTLE, CHECK).
//
// Parameters:
//   SETTLE_CYC : cycles between driving a vector and sampling (1..15, 0 -> 1)
//   VEC_W      : stimulus vector width, fixed at 8
//
// Ports:
//   clk            : system clock, rising edge
//   rst            : synchronous active-high reset
//   start          : single-cycle pulse, begins a run (ignored while busy)
//   resp_y[3:0]    : Y outputs of the part under test
//   stim_a[3:0]    : registered A inputs to the part
//   stim_b[3:0]    : registered B inputs to the part
//   busy           : run in progress
//   done           : run finished, held until the next accepted start
//   pass           : valid with done; 1 when no mismatches were seen
//   err_count[8:0] : mismatching vectors (0..256)
//   first_fail_vec : {b,a} of the first mismatch, 0xFF if none
//
// Build option:
//   HC86_SELFTEST_STOP_ON_FAIL_EN : when defined, the first mismatch ends the
//   run immediately (err_count=1, first_fail_vec=that vector, pass=0).
// -----------------------------------------------------------------------------
module hc86_selftest_seq #(
  parameter int SETTLE_CYC = 2,
  parameter int VEC_W      = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       resp_y,
  output logic [3:0]       stim_a,
  output logic [3:0]       stim_b,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [8:0]       err_count,
  output logic [VEC_W-1:0] first_fail_vec
);

  import hc_selftest_pkg::*;

  localparam int         SETTLE_EFF  = settle_len(SETTLE_CYC);
  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_EFF - 1);
  localparam logic [VEC_W-1:0] LAST_VEC = '1;

  state_t           state, state_next;
  logic [VEC_W-1:0] vec;
  logic [3:0]       settle_cnt;
  logic [3:0]       expected_y;
  logic             mismatch;
  logic [8:0]       err_next;

  hc86_ref_model u_ref (
    .a (stim_a),
    .b (stim_b),
    .y (expected_y)
  );

  // Only meaningful in CHECK; stim_a/stim_b hold vec throughout the vector.
  assign mismatch = (resp_y != expected_y);
  assign err_next = err_count + {8'd0, mismatch};

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: registers use non-blocking assignments so every flop samples the
  // pre-edge values of the others; blocking here would create ordering races.
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: default assigned first so no path through the case leaves
    // state_next unassigned, which would infer a latch.
    state_next = state;
    unique case (state)
      ST_IDLE, ST_DONE: begin
        if (start) state_next = ST_DRIVE;
      end
      ST_DRIVE: begin
        state_next = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (settle_cnt == SETTLE_LAST) state_next = ST_CHECK;
      end
      ST_CHECK: begin
`ifdef HC86_SELFTEST_STOP_ON_FAIL_EN
        if (mismatch || vec == LAST_VEC) state_next = ST_DONE;
        else                             state_next = ST_DRIVE;
`else
        if (vec == LAST_VEC) state_next = ST_DONE;
        else                 state_next = ST_DRIVE;
`endif
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath and status registers
  // ---------------------------------------------------------------------------
  // Reset is synchronous and checked before anything else, so a reset landing
  // mid-run wins over CHECK updates and a coincident start.
  always_ff @(posedge clk) begin
    if (rst) begin
      vec            <= '0;
      settle_cnt     <= '0;
      stim_a         <= '0;
      stim_b         <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
      err_count      <= '0;
      first_fail_vec <= NO_FAIL;
    end else begin
      unique case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            vec            <= '0;
            err_count      <= '0;
            first_fail_vec <= NO_FAIL;
            done           <= 1'b0;
            pass           <= 1'b0;
            busy           <= 1'b1;
          end
        end
        ST_DRIVE: begin
          stim_a     <= vec[3:0];
          stim_b     <= vec[7:4];
          settle_cnt <= '0;
        end
        ST_SETTLE: begin
          settle_cnt <= settle_cnt + 4'd1;
        end
        ST_CHECK: begin
          if (mismatch) begin
            err_count <= err_next;
            // 0xFF is itself a legal failing vector, so the zero count is what
            // actually marks "nothing recorded yet".
            if (first_fail_vec == NO_FAIL && err_count == 9'd0)
              first_fail_vec <= vec;
          end
          if (state_next == ST_DONE) begin
            busy <= 1'b0;
            done <= 1'b1;
            pass <= (err_next == 9'd0);
          end else begin
            vec <= vec + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
